// File: rtl/opentitan_soc_pkg.sv
// Shared types and constants for the serial-boot command sequencer SoC shell.
package opentitan_soc_pkg;

  typedef enum logic [3:0] {
    OP_HALT = 4'h0,
    OP_GPIO = 4'h1,
    OP_TX   = 4'h2,
    OP_WAIT = 4'h3,
    OP_POLL = 4'h4,
    OP_RXB  = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_e;

  // Sub-steps of a RUN command: RAM read, decode/execute, multi-cycle stall.
  typedef enum logic [1:0] {PH_FETCH, PH_EXEC, PH_BUSY} phase_e;

  localparam logic [31:0] END_MARKER = 32'h0000_0FFF;

endpackage

// File: rtl/soc_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch-rejecting start, byte plus one-cycle valid.
module soc_uart_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e       state;
  logic            rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data    <= '0;
      valid   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      valid   <= 1'b0;
      case (state)
        RX_IDLE: if (rx_prev && !rx_sync) begin
          state <= RX_START;
          cnt   <= '0;
        end
        // Half a bit later the line must still be low, otherwise it was a glitch.
        RX_START: if (cnt == CW'(CPB/2 - 1)) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RX_DATA: if (cnt == CW'(CPB - 1)) begin
          cnt     <= '0;
          shift   <= {rx_sync, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= RX_STOP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RX_STOP: if (cnt == CW'(CPB - 1)) begin
          state <= RX_IDLE;
          if (rx_sync) begin
            data  <= shift;
            valid <= 1'b1;
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/opentitan_soc_top.sv
// SoC shell: serial boot loader into program RAM, then a small GPIO/UART command sequencer.
module opentitan_soc_top
  import opentitan_soc_pkg::*;
#(
  parameter logic [31:0] JTAG_ID      = 32'h0000_0001,
  parameter logic        DirectDmiTap = 1'b1,
  parameter int          CLK_FREQ     = 100_000_000,
  parameter int          BAUD         = 9600,
  parameter int          IMEM_WORDS   = 512
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        uart_rx_inst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        uart_txen,
  input  logic [19:0] gpio_i,
  output logic [19:0] gpio_o
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(IMEM_WORDS);

  logic [31:0]   ram [IMEM_WORDS];
  logic [31:0]   ram_q;
  logic [AW:0]   wptr, pc;
  logic [23:0]   word_buf;
  logic [1:0]    byte_cnt;
  state_e        state;
  phase_e        phase;
  logic [23:0]   wait_cnt;
  logic [19:0]   gpio_meta, gpio_sync;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [8:0]    tx_shift;
  logic          boot_valid, run_valid;
  logic [7:0]    boot_data, run_data;
  logic [31:0]   boot_word, gpio_ext;
  logic          ram_we, tx_last, poll_hit;
  opcode_e       op;
  logic          unused_bits;

  assign unused_bits = ^{JTAG_ID, DirectDmiTap, ram_q[27:24]};

  soc_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_boot_rx (
    .clk(clk_i), .rst(rst_i), .rx(uart_rx_inst), .data(boot_data), .valid(boot_valid)
  );

  soc_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_run_rx (
    .clk(clk_i), .rst(rst_i), .rx(uart_rx), .data(run_data), .valid(run_valid)
  );

  assign boot_word = {boot_data, word_buf};
  assign ram_we    = (state == LOAD) && boot_valid && (byte_cnt == 2'd3) && (boot_word != END_MARKER);
  assign op        = opcode_e'(ram_q[31:28]);
  assign tx_last   = uart_txen && (tx_bits == 4'd9) && (tx_cnt == CW'(CPB - 1));
  assign gpio_ext  = {12'b0, gpio_sync};
  assign poll_hit  = gpio_ext[ram_q[4:0]] == ram_q[8];

  // pc only moves in PH_FETCH transitions, so ram_q holds the current command while busy.
  always_ff @(posedge clk_i) begin
    if (ram_we) ram[wptr[AW-1:0]] <= boot_word;
    ram_q <= ram[pc[AW-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= LOAD;
      phase     <= PH_FETCH;
      wptr      <= '0;
      pc        <= '0;
      word_buf  <= '0;
      byte_cnt  <= '0;
      wait_cnt  <= '0;
      gpio_meta <= '0;
      gpio_sync <= '0;
      gpio_o    <= '0;
      uart_tx   <= 1'b1;
      uart_txen <= 1'b0;
      tx_cnt    <= '0;
      tx_bits   <= '0;
      tx_shift  <= '0;
    end else begin
      gpio_meta <= gpio_i;
      gpio_sync <= gpio_meta;

      if (uart_txen) begin
        if (tx_cnt == CW'(CPB - 1)) begin
          tx_cnt <= '0;
          if (tx_bits == 4'd9) begin
            uart_txen <= 1'b0;
            uart_tx   <= 1'b1;
          end else begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_bits  <= tx_bits + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end

      case (state)
        LOAD: if (boot_valid) begin
          byte_cnt <= byte_cnt + 2'd1;
          word_buf <= {boot_data, word_buf[23:8]};
          if (byte_cnt == 2'd3) begin
            if (boot_word == END_MARKER) begin
              state <= RUN;
              phase <= PH_FETCH;
              pc    <= '0;
            end else begin
              wptr <= wptr + (AW+1)'(1);
              if (wptr == (AW+1)'(IMEM_WORDS - 1)) begin
                state <= RUN;
                phase <= PH_FETCH;
                pc    <= '0;
              end
            end
          end
        end
        RUN: case (phase)
          PH_FETCH: if (pc == wptr) state <= HALT;
                    else phase <= PH_EXEC;
          PH_EXEC: case (op)
            OP_HALT: state <= HALT;
            OP_GPIO: begin
              gpio_o <= ram_q[19:0];
              pc     <= pc + (AW+1)'(1);
              phase  <= PH_FETCH;
            end
            OP_TX: begin
              uart_tx   <= 1'b0;
              uart_txen <= 1'b1;
              tx_cnt    <= '0;
              tx_bits   <= '0;
              tx_shift  <= {1'b1, ram_q[7:0]};
              phase     <= PH_BUSY;
            end
            OP_WAIT: if (ram_q[23:0] == 24'd0) begin
              pc    <= pc + (AW+1)'(1);
              phase <= PH_FETCH;
            end else begin
              wait_cnt <= ram_q[23:0];
              phase    <= PH_BUSY;
            end
            OP_POLL: if (ram_q[4:0] >= 5'd20) state <= HALT;
                     else phase <= PH_BUSY;
            OP_RXB:  phase <= PH_BUSY;
            default: begin
              pc    <= pc + (AW+1)'(1);
              phase <= PH_FETCH;
            end
          endcase
          PH_BUSY: case (op)
            OP_TX: if (tx_last) begin
              pc    <= pc + (AW+1)'(1);
              phase <= PH_FETCH;
            end
            OP_WAIT: if (wait_cnt == 24'd1) begin
              pc    <= pc + (AW+1)'(1);
              phase <= PH_FETCH;
            end else begin
              wait_cnt <= wait_cnt - 24'd1;
            end
            OP_POLL: if (poll_hit) begin
              pc    <= pc + (AW+1)'(1);
              phase <= PH_FETCH;
            end
            OP_RXB: if (run_valid) begin
              gpio_o[7:0] <= run_data;
              pc          <= pc + (AW+1)'(1);
              phase       <= PH_FETCH;
            end
            default: begin
              pc    <= pc + (AW+1)'(1);
              phase <= PH_FETCH;
            end
          endcase
          default: phase <= PH_FETCH;
        endcase
        HALT: state <= HALT;
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_opentitan_soc_top.sv
// Directed bench: boots short programs over the boot UART and checks GPIO/UART behaviour.
module tb_opentitan_soc_top;
  localparam int TB_CLK  = 6_400_000;
  localparam int TB_BAUD = 100_000;
  localparam int CPB     = TB_CLK / TB_BAUD;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        uart_rx_inst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_tx, uart_txen;
  logic [19:0] gpio_i = '0;
  logic [19:0] gpio_o;

  int n_cmp  = 0;
  int n_fail = 0;

  opentitan_soc_top #(
    .CLK_FREQ(TB_CLK), .BAUD(TB_BAUD), .IMEM_WORDS(512)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .uart_rx_inst(uart_rx_inst), .uart_rx(uart_rx),
    .uart_tx(uart_tx), .uart_txen(uart_txen), .gpio_i(gpio_i), .gpio_o(gpio_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Frame on either serial line; the stop bit/idle time is held for stop_cycles.
  task automatic send_byte(input bit boot, input logic [7:0] b, input int cpb, input int stop_cycles);
    logic [8:0] fr;
    fr = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      if (boot) uart_rx_inst = fr[i]; else uart_rx = fr[i];
      repeat (cpb) @(negedge clk_i);
    end
    if (boot) uart_rx_inst = 1'b1; else uart_rx = 1'b1;
    repeat (stop_cycles) @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] w, input int cpb, input int last_stop);
    for (int k = 0; k < 4; k++)
      send_byte(1'b1, w[8*k +: 8], cpb, (k == 3) ? last_stop : cpb);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    uart_rx_inst = 1'b1;
    uart_rx = 1'b1;
    gpio_i = '0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic wait_gpio(input string tag, input logic [19:0] exp, input int bound);
    int n;
    n = 0;
    while (gpio_o !== exp && n < bound) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, {12'b0, gpio_o}, {12'b0, exp});
  endtask

  initial begin
    int         n;
    logic [9:0] txbits;

    // Reset state, during and after reset
    repeat (4) @(negedge clk_i);
    chk("rst_gpio", {12'b0, gpio_o}, 32'd0);
    chk("rst_tx", {31'b0, uart_tx}, 32'd1);
    chk("rst_txen", {31'b0, uart_txen}, 32'd0);
    rst_i = 1'b0;
    repeat (20) @(negedge clk_i);
    chk("idle_gpio", {12'b0, gpio_o}, 32'd0);
    chk("idle_tx", {31'b0, uart_tx}, 32'd1);
    chk("idle_txen", {31'b0, uart_txen}, 32'd0);

    // GPIO command, sender at CPB+1 clocks per bit
    send_word(32'h1000_00AB, CPB + 1, CPB + 1);
    send_word(32'h0000_0FFF, CPB + 1, 1);
    wait_gpio("gpio_ab", 20'h000AB, 100);
    chk("gpio_txen", {31'b0, uart_txen}, 32'd0);
    chk("gpio_tx", {31'b0, uart_tx}, 32'd1);

    // TX command: frame bit pattern and txen width
    do_reset();
    send_word(32'h2000_0055, CPB, CPB);
    send_word(32'h0000_0FFF, CPB, 1);
    n = 0;
    while (uart_txen !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("tx_started", {31'b0, uart_txen}, 32'd1);
    n = 0;
    txbits = '0;
    while (uart_txen === 1'b1 && n < 20 * CPB) begin
      if ((n % CPB) == CPB / 2 && (n / CPB) < 10) txbits[n / CPB] = uart_tx;
      @(negedge clk_i);
      n++;
    end
    chk("tx_bits", {22'b0, txbits}, 32'h0000_02AA);
    chk("tx_len", n, 10 * CPB);
    chk("tx_gpio", {12'b0, gpio_o}, 32'd0);

    // POLL on gpio_i[3]==1, then GPIO 1
    do_reset();
    send_word(32'h4000_0103, CPB + 1, CPB + 1);
    send_word(32'h1000_0001, CPB + 1, CPB + 1);
    send_word(32'h0000_0FFF, CPB + 1, CPB + 1);
    repeat (200) @(negedge clk_i);
    chk("poll_wait", {12'b0, gpio_o}, 32'd0);
    gpio_i = 20'h00004;
    repeat (50) @(negedge clk_i);
    chk("poll_wrongbit", {12'b0, gpio_o}, 32'd0);
    gpio_i = 20'h00008;
    wait_gpio("poll_hit", 20'h00001, 20);

    // RXB: byte on runtime UART lands in gpio_o[7:0]
    do_reset();
    send_word(32'h5000_0000, CPB + 1, CPB + 1);
    send_word(32'h0000_0FFF, CPB + 1, CPB + 1);
    repeat (100) @(negedge clk_i);
    chk("rxb_wait", {12'b0, gpio_o}, 32'd0);
    send_byte(1'b0, 8'h3C, CPB + 1, CPB + 1);
    wait_gpio("rxb_byte", 20'h0003C, 50);

    // Asynchronous reset clears outputs without a clock edge
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 chk("async_rst", {12'b0, gpio_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Reset mid-load discards the partial word
    send_byte(1'b1, 8'h77, CPB + 1, CPB + 1);
    send_byte(1'b1, 8'h66, CPB + 1, CPB + 1);
    #3 rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    send_word(32'h1000_0005, CPB + 1, CPB + 1);
    send_word(32'h0000_0FFF, CPB + 1, 1);
    wait_gpio("midload_rst", 20'h00005, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
